// File: rtl/fsm_stream_arbiter.sv
// fsm_stream_arbiter
//   Shares one serial Moore sequence detector between N_REQ requesters.
//   A winner is chosen, the detector is cleared, the winner's WORD_W-bit
//   word is shifted out MSB-first on x, the detector's high samples are
//   counted, and the count is returned with a one-cycle done/ack pulse.
//
// Ports
//   clk      : clock, all state updates on posedge
//   rst_n    : asynchronous active-low reset
//   req      : per-requester request level, held until ack
//   data_in  : packed words, requester i at [i*WORD_W +: WORD_W]
//   y_in     : detector Moore output
//   x        : serial bit to detector (0 outside SHIFT)
//   det_clr  : one-cycle synchronous clear to detector
//   grant    : one-hot owner of the detector, zero when idle
//   busy     : high in every state except IDLE
//   ack      : one-cycle pulse to the served requester
//   done     : one-cycle completion pulse
//   done_id  : served requester index, valid with done
//   hit_cnt  : count of high y_in samples, valid with done, held after
//
// Build option
//   FSM_ARB_FIXED_PRIO_EN : fixed priority (lowest index wins) instead of
//                           round-robin; the round-robin pointer is removed.
module fsm_stream_arbiter #(
  parameter int WORD_W = 8,
  parameter int N_REQ  = 4,
  parameter int CNT_W  = $clog2(WORD_W + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*WORD_W-1:0]     data_in,
  input  logic                        y_in,
  output logic                        x,
  output logic                        det_clr,
  output logic [N_REQ-1:0]            grant,
  output logic                        busy,
  output logic [N_REQ-1:0]            ack,
  output logic                        done,
  output logic [$clog2(N_REQ)-1:0]    done_id,
  output logic [CNT_W-1:0]            hit_cnt
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int BC_W = $clog2(WORD_W);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_t;

  state_t              state_reg, state_next;
  logic [WORD_W-1:0]   shift_reg, shift_next;
  logic [BC_W-1:0]     bit_cnt_reg, bit_cnt_next;
  logic [CNT_W-1:0]    acc_reg, acc_next;
  logic [ID_W-1:0]     winner_reg, winner_next;
  logic                x_reg, x_next;
  logic                det_clr_reg, det_clr_next;
  logic [N_REQ-1:0]    grant_reg, grant_next;
  logic                busy_reg, busy_next;
  logic [N_REQ-1:0]    ack_reg, ack_next;
  logic                done_reg, done_next;
  logic [ID_W-1:0]     done_id_reg, done_id_next;
  logic [CNT_W-1:0]    hit_cnt_reg, hit_cnt_next;

  logic [ID_W-1:0]     win;
  logic                found;

`ifdef FSM_ARB_FIXED_PRIO_EN
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        win   = ID_W'(i);
      end
    end
  end
`else
  logic [ID_W-1:0]     ptr_reg, ptr_next;
  logic [N_REQ-1:0]    req_rot;
  int                  sum;

  // Rotate req so the pointer position lands on bit 0, then take the
  // first set bit and map it back to an absolute index.
  always_comb begin
    win     = '0;
    found   = 1'b0;
    sum     = 0;
    req_rot = N_REQ'({req, req} >> ptr_reg);
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_rot[i]) begin
        found = 1'b1;
        sum   = int'(ptr_reg) + i;
        if (sum >= N_REQ) sum = sum - N_REQ;
        win   = ID_W'(sum);
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      acc_reg     <= '0;
      winner_reg  <= '0;
      x_reg       <= 1'b0;
      det_clr_reg <= 1'b0;
      grant_reg   <= '0;
      busy_reg    <= 1'b0;
      ack_reg     <= '0;
      done_reg    <= 1'b0;
      done_id_reg <= '0;
      hit_cnt_reg <= '0;
`ifndef FSM_ARB_FIXED_PRIO_EN
      ptr_reg     <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      acc_reg     <= acc_next;
      winner_reg  <= winner_next;
      x_reg       <= x_next;
      det_clr_reg <= det_clr_next;
      grant_reg   <= grant_next;
      busy_reg    <= busy_next;
      ack_reg     <= ack_next;
      done_reg    <= done_next;
      done_id_reg <= done_id_next;
      hit_cnt_reg <= hit_cnt_next;
`ifndef FSM_ARB_FIXED_PRIO_EN
      ptr_reg     <= ptr_next;
`endif
    end
  end

  // Outputs are registered: each *_next describes the value the output
  // takes in the state being entered.
  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    acc_next     = acc_reg;
    winner_next  = winner_reg;
    x_next       = 1'b0;
    det_clr_next = 1'b0;
    grant_next   = grant_reg;
    busy_next    = busy_reg;
    ack_next     = '0;
    done_next    = 1'b0;
    done_id_next = done_id_reg;
    hit_cnt_next = hit_cnt_reg;
`ifndef FSM_ARB_FIXED_PRIO_EN
    ptr_next     = ptr_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (found) begin
          state_next   = CLEAR;
          winner_next  = win;
          grant_next   = ONE_HOT0 << win;
          busy_next    = 1'b1;
          shift_next   = data_in[int'(win)*WORD_W +: WORD_W];
          acc_next     = '0;
          bit_cnt_next = '0;
          det_clr_next = 1'b1;
        end
      end
      CLEAR: begin
        state_next   = SHIFT;
        x_next       = shift_reg[WORD_W-1];
        shift_next   = {shift_reg[WORD_W-2:0], 1'b0};
        bit_cnt_next = '0;
      end
      SHIFT: begin
        // The detector answers one cycle after a bit, so bit 0's response
        // is sampled in SHIFT cycle 1 and the last bit's in DRAIN.
        if (bit_cnt_reg != '0) acc_next = acc_reg + CNT_W'(y_in);
        if (bit_cnt_reg == BC_W'(WORD_W - 1)) begin
          state_next = DRAIN;
        end else begin
          x_next       = shift_reg[WORD_W-1];
          shift_next   = {shift_reg[WORD_W-2:0], 1'b0};
          bit_cnt_next = bit_cnt_reg + 1'b1;
        end
      end
      DRAIN: begin
        state_next   = DONE;
        acc_next     = acc_reg + CNT_W'(y_in);
        hit_cnt_next = acc_reg + CNT_W'(y_in);
        done_next    = 1'b1;
        ack_next     = ONE_HOT0 << winner_reg;
        done_id_next = winner_reg;
      end
      DONE: begin
        state_next = IDLE;
        grant_next = '0;
        busy_next  = 1'b0;
`ifndef FSM_ARB_FIXED_PRIO_EN
        ptr_next   = (winner_reg == ID_W'(N_REQ - 1)) ? '0 : winner_reg + 1'b1;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  assign x       = x_reg;
  assign det_clr = det_clr_reg;
  assign grant   = grant_reg;
  assign busy    = busy_reg;
  assign ack     = ack_reg;
  assign done    = done_reg;
  assign done_id = done_id_reg;
  assign hit_cnt = hit_cnt_reg;

endmodule

// File: tb/tb_fsm_stream_arbiter.sv
// Testbench for fsm_stream_arbiter: directed stimulus feeds a scoreboard
// queue; a negedge monitor checks every done pulse against it.
module tb_fsm_stream_arbiter;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] data_in = '0;
  logic           y_in;
  logic           x, det_clr, busy, done;
  logic [N-1:0]   grant, ack;
  logic [1:0]     done_id;
  logic [CW-1:0]  hit_cnt;

  fsm_stream_arbiter #(.WORD_W(W), .N_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .y_in(y_in),
    .x(x), .det_clr(det_clr), .grant(grant), .busy(busy), .ack(ack),
    .done(done), .done_id(done_id), .hit_cnt(hit_cnt)
  );

  always #5 clk = ~clk;

  // Detector model: 0 = y follows x one cycle late, 1 = tied high, 2 = tied low
  int   y_mode = 0;
  logic x_d;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) x_d <= 1'b0;
    else        x_d <= det_clr ? 1'b0 : x;
  assign y_in = (y_mode == 1) ? 1'b1 : (y_mode == 2) ? 1'b0 : x_d;

  typedef struct {
    int         id;
    int         cnt;
    logic [7:0] word;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  int tests = 0;
  int fails = 0;
  int done_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push(input int id, input int cnt, input logic [7:0] word);
    exp_t t;
    t.id = id; t.cnt = cnt; t.word = word;
    sb.push_back(t);
  endtask

  // Monitor
  int         cyc = 0, t0 = 0, nclr = 0, bitpos = 0, last_done = -1;
  logic       cap = 1'b0;
  logic       b2b = 1'b0;
  logic [7:0] xs = '0;
  logic [N-1:0] pg = '0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      cap = 1'b0; pg = '0; bitpos = 0; nclr = 0;
    end else begin
      if (grant != '0 && pg == '0) begin t0 = cyc; nclr = 0; end
      pg = grant;
      if (cap) begin
        xs = {xs[6:0], x};
        bitpos++;
        if (bitpos == 8) cap = 1'b0;
      end else if (grant != '0) begin
        chk("x_outside_shift", {31'd0, x}, 32'd0);
      end
      if (det_clr) begin nclr++; cap = 1'b1; bitpos = 0; end
      if (done) begin
        done_seen++;
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got done_id %0d expected no done", done_id);
        end else begin
          e = sb.pop_front();
          $display("[TB] done id=%0d hit_cnt=%0d x=%02h", done_id, hit_cnt, xs);
          chk("done_id", {30'd0, done_id}, e.id);
          chk("hit_cnt", {28'd0, hit_cnt}, e.cnt);
          chk("ack", {28'd0, ack}, 32'd1 << e.id);
          chk("grant_at_done", {28'd0, grant}, 32'd1 << e.id);
          chk("busy_at_done", {31'd0, busy}, 32'd1);
          chk("x_sequence", {24'd0, xs}, {24'd0, e.word});
          chk("grant_to_done", cyc - t0, 32'd10);
          chk("det_clr_pulses", nclr, 32'd1);
          if (b2b && last_done >= 0) chk("throughput", cyc - last_done, 32'd12);
          last_done = cyc;
        end
      end
    end
  end

  task automatic wait_dones(input int n);
    int k = 0;
    while (done_seen < n && k < 300) begin @(negedge clk); #1; k++; end
    if (done_seen < n) chk("timeout_done", done_seen, n);
  endtask

  task automatic wait_clr();
    int k = 0;
    while (!det_clr && k < 300) begin @(negedge clk); #1; k++; end
    if (!det_clr) chk("timeout_det_clr", {31'd0, det_clr}, 32'd1);
  endtask

  task automatic set_word(input int i, input logic [7:0] w);
    data_in[i*W +: W] = w;
  endtask

  initial begin
    set_word(0, 8'h0F); set_word(1, 8'h81); set_word(2, 8'hA5); set_word(3, 8'hFF);
    req = 4'b1111;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_x", {31'd0, x}, 32'd0);
    chk("rst_det_clr", {31'd0, det_clr}, 32'd0);
    chk("rst_ack", {28'd0, ack}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_done_id", {30'd0, done_id}, 32'd0);
    chk("rst_hit_cnt", {28'd0, hit_cnt}, 32'd0);

    // Fairness with all requests held
    b2b = 1'b1;
`ifdef FSM_ARB_FIXED_PRIO_EN
    push(0, 4, 8'h0F); push(0, 4, 8'h0F); push(0, 4, 8'h0F);
    push(0, 4, 8'h0F); push(0, 4, 8'h0F);
`else
    push(0, 4, 8'h0F); push(1, 2, 8'h81); push(2, 4, 8'hA5);
    push(3, 8, 8'hFF); push(0, 4, 8'h0F);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("grant_after_reset", {28'd0, grant}, 32'd1);
    wait_dones(4);
    @(negedge clk); #1;
    @(negedge clk); #1;
    req = '0;
    wait_dones(5);
    b2b = 1'b0;

    // Single word from requester 2
    y_mode = 0; set_word(2, 8'hA5); req = 4'b0100;
    push(2, 4, 8'hA5);
    wait_dones(6); req = '0;

    // Detector output tied high, then tied low
    y_mode = 1; set_word(1, 8'h81); req = 4'b0010;
    push(1, 8, 8'h81);
    wait_dones(7); req = '0;
    y_mode = 2; req = 4'b0010;
    push(1, 0, 8'h81);
    wait_dones(8); req = '0;

    // Request dropped and data changed during SHIFT
    y_mode = 0; set_word(1, 8'h3C); req = 4'b0010;
    push(1, 4, 8'h3C);
    wait_clr();
    repeat (3) begin @(negedge clk); #1; end
    req = '0; set_word(1, 8'h00);
    wait_dones(9);

    // Reset during SHIFT after three bits
    y_mode = 1; req = 4'b1000;
    wait_clr();
    repeat (3) begin @(negedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("abort_grant", {28'd0, grant}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_x", {31'd0, x}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_ack", {28'd0, ack}, 32'd0);
    repeat (3) begin @(negedge clk); #1; end
    chk("abort_no_done", done_seen, 32'd9);
    y_mode = 0; set_word(0, 8'h01); req = 4'b1001;
    push(0, 1, 8'h01);
    rst_n = 1'b1;
    wait_dones(10); req = '0;

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
